// File: rtl/ieeedrv_rom_loader.sv
// Drive ROM loader: writes the host download stream into the shared drive ROM,
// keeps drive CPUs in reset until a complete image has settled, then yields the port.
module ieeedrv_rom_loader #(
    parameter int ADDRWIDTH   = 14,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 dl_active,
    input  logic                 dl_wr,
    input  logic [ADDRWIDTH-1:0] dl_addr,
    input  logic [7:0]           dl_data,
    input  logic [ADDRWIDTH-1:0] mux_addr,
    output logic [ADDRWIDTH-1:0] rom_addr,
    output logic [7:0]           rom_data,
    output logic                 rom_wren,
    output logic                 drv_reset,
    output logic                 rom_valid,
    output logic [ADDRWIDTH:0]   byte_count,
    output logic [7:0]           checksum,
    output logic                 overflow
);

    localparam int CW = ADDRWIDTH + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] FULL_C    = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          byte_count_q, byte_count_d;
    logic [7:0]             checksum_q, checksum_d;
    logic                   overflow_q, overflow_d;
    logic [ADDRWIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   wr_pend_q, wr_pend_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   drv_reset_q, rom_valid_q;
    logic                   load_entry_s;

    // Next-state and download bookkeeping
    always_comb begin
        state_d      = state_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;
        overflow_d   = overflow_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_pend_d    = 1'b0;
        hold_d       = hold_q;
        load_entry_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (dl_active) begin
                    load_entry_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (dl_wr) begin
                    if (byte_count_q != FULL_C) begin
                        wr_addr_d    = dl_addr;
                        wr_data_d    = dl_data;
                        wr_pend_d    = 1'b1;
                        byte_count_d = byte_count_q + CW'(1);
                        checksum_d   = checksum_q + dl_data;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    wr_pend_d = 1'b0;
                end
                // A strobe coinciding with the dl_active fall is still taken above.
                if (!dl_active) begin
                    state_d = HOLD;
                    hold_d  = HOLD_INIT;
                end else begin
                    state_d = LOAD;
                end
            end
            HOLD: begin
                if (dl_active) begin
                    load_entry_s = 1'b1;
                end else if (hold_q == {HW{1'b0}}) begin
                    state_d = (byte_count_q != {CW{1'b0}}) ? RUN : IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            RUN: begin
                if (dl_active) begin
                    load_entry_s = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_entry_s) begin
            state_d      = LOAD;
            byte_count_d = {CW{1'b0}};
            checksum_d   = 8'h00;
            overflow_d   = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            byte_count_q <= {CW{1'b0}};
            checksum_q   <= 8'h00;
            overflow_q   <= 1'b0;
            wr_addr_q    <= {ADDRWIDTH{1'b0}};
            wr_data_q    <= 8'h00;
            wr_pend_q    <= 1'b0;
            hold_q       <= {HW{1'b0}};
            drv_reset_q  <= 1'b1;
            rom_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
            overflow_q   <= overflow_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_pend_q    <= wr_pend_d;
            hold_q       <= hold_d;
            drv_reset_q  <= (state_d != RUN);
            rom_valid_q  <= (state_d == RUN);
        end
    end

    // ROM port ownership; the HOLD term flushes a write accepted in the last LOAD cycle
    always_comb begin
        if ((state_q == LOAD) || ((state_q == HOLD) && wr_pend_q)) begin
            rom_addr = wr_addr_q;
            rom_data = wr_data_q;
            rom_wren = wr_pend_q;
        end else begin
            rom_addr = mux_addr;
            rom_data = 8'h00;
            rom_wren = 1'b0;
        end
    end

    assign drv_reset  = drv_reset_q;
    assign rom_valid  = rom_valid_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/ieeedrv_rom_loader.md
# ieeedrv_rom_loader

Loads a drive firmware image from the host download stream into the shared drive ROM, then hands the ROM port over to the per-drive ROM multiplexer. Sits directly upstream of the ROM multiplexer, between the host download interface and the single-port drive ROM. Holds all drive CPUs in reset while the image is absent or being written, plus a settle interval afterwards. Reports byte count, 8-bit checksum and overflow for host-side diagnostics.

## Interface

- ADDRWIDTH, 14: ROM address width; capacity = 2^ADDRWIDTH bytes
- HOLD_CYCLES, 16: cycles drv_reset stays asserted after download end (≥1)

- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- dl_active  in  1  level; high while host download of this ROM is in progress
- dl_wr  in  1  single-cycle write strobe, qualified by dl_active
- dl_addr  in  ADDRWIDTH  byte address of dl_data
- dl_data  in  8  download byte
- mux_addr  in  ADDRWIDTH  ROM address from the ROM multiplexer
- rom_addr  out  ADDRWIDTH  ROM port address
- rom_data  out  8  ROM write data
- rom_wren  out  1  ROM write enable
- drv_reset  out  1  reset to all drive CPUs, active high
- rom_valid  out  1  ROM holds a complete image; multiplexer data usable
- byte_count  out  ADDRWIDTH+1  bytes accepted in the last/current download
- checksum  out  8  mod-256 sum of accepted bytes
- overflow  out  1  more than 2^ADDRWIDTH writes attempted in this download

## Operation

- States: IDLE, LOAD, HOLD, RUN. Reset → IDLE.
- drv_reset = (state != RUN); rom_valid = (state == RUN); both decoded from the state register.
- IDLE: dl_active=1 → LOAD.
- Entry into LOAD (from any state): byte_count, checksum, overflow cleared in the transition cycle.
- LOAD, dl_wr=1 and byte_count < 2^ADDRWIDTH: wr_addr←dl_addr, wr_data←dl_data, wr_pend←1; byte_count+1; checksum+dl_data (8-bit wrap).
- LOAD, dl_wr=1 and byte_count = 2^ADDRWIDTH: write suppressed (wr_pend←0), overflow←1 (sticky until next LOAD entry), byte_count saturates, checksum unchanged.
- LOAD, dl_wr=0: wr_pend←0.
- LOAD, dl_active=0 → HOLD, hold counter←HOLD_CYCLES−1. A dl_wr in the same cycle as the fall is still accepted.
- HOLD: counter decrements each cycle; at 0 → RUN if byte_count≠0, else → IDLE. dl_active=1 in HOLD → LOAD (priority over countdown).
- RUN: dl_active=1 → LOAD.
- dl_wr outside LOAD ignored (no counting, no write).
- Port mux (combinational): in LOAD, rom_addr=wr_addr, rom_data=wr_data, rom_wren=wr_pend; otherwise rom_addr=mux_addr, rom_data=0, rom_wren=0.
- Mid-operation reset_n assertion: immediately IDLE, drv_reset=1, rom_valid=0; partial ROM contents left as-is but never flagged valid.

## Timing

- Reset values: state=IDLE, rom_wren=0, drv_reset=1, rom_valid=0, byte_count=0, checksum=0, overflow=0, wr_pend=0, rom_data=0, rom_addr=mux_addr.
- dl_wr accepted at edge n → rom_wren=1 with addr/data during cycle n+1; byte_count/checksum updated in cycle n+1. Back-to-back strobes give one write per cycle; no backpressure.
- Last pending write still issues in first HOLD cycle? No: port switches to mux_addr on HOLD entry, so a write accepted in the final LOAD cycle is issued in HOLD's first cycle via a one-cycle wren extension: rom_wren=wr_pend and rom_addr=wr_addr also when state=HOLD and wr_pend=1; wr_pend clears after that cycle.
- dl_active falls, sampled low at edge n → HOLD from n+1 for HOLD_CYCLES cycles → RUN (drv_reset=0, rom_valid=1) from cycle n+1+HOLD_CYCLES.
- dl_active sampled high at edge n in RUN/IDLE/HOLD → LOAD from n+1; drv_reset=1, rom_valid=0 in that same cycle.
- In RUN the mux_addr→rom_addr path adds zero cycles; multiplexer read latency unchanged.

## Test plan

- Reset: hold reset_n=0, toggle inputs → drv_reset=1, rom_valid=0, rom_wren=0, counters 0; rom_addr tracks mux_addr.
- Load 4 bytes 0x10,0x20,0x30,0xF5 at addr 0..3, drop dl_active → four rom_wren pulses one cycle after each strobe, checksum=0x55, byte_count=4, RUN exactly HOLD_CYCLES cycles after HOLD entry; read back via mux_addr matches.
- Empty download: dl_active pulse with no dl_wr → HOLD then IDLE, drv_reset stays 1, rom_valid=0.
- Overflow, ADDRWIDTH=4: 17 writes → 16 rom_wren pulses, byte_count=16, overflow=1; overflow clears on next dl_active rise.
- Reload in RUN: dl_active rises → drv_reset=1, rom_valid=0 next cycle, counters cleared; final-cycle write (dl_wr with dl_active fall) lands in ROM.
- Reset mid-load after 2 of 4 bytes → IDLE immediately, rom_valid=0, rom_wren=0, byte_count=0.
